// File: rtl/pipe_ctrl_pkg.sv
// Package: pipe_ctrl_pkg
// Shared types and default widths for the pipeline hazard controller.
//   ctrl_state_t  : controller state (RUN / MEM_WAIT / DROP)
//   REG_AW_DEFAULT: register-index width
//   CNT_W_DEFAULT : perf counter width
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;
    localparam int unsigned CNT_W_DEFAULT  = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DROP     = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Module: sat_counter
// Saturating up-counter used for the hazard perf counters.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (clears count)
//   inc   : increment enable for this cycle
//   count : current count, holds at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Module: pipeline_hazard_ctrl
// Stall/flush scheduler for a 5-stage pipeline. Resolves load-use, EX redirects,
// fetch latency and dmem back-pressure; counts stall and flush cycles.
// Ports:
//   clk, rst                : clock and asynchronous active-low reset
//   Rs1_D, Rs2_D            : decode-stage source indices
//   Rd_E, MemRead_E         : execute-stage destination and load flag
//   PCSrc_E                 : redirect resolved in E
//   imem_valid_F            : fetch data valid this cycle
//   dmem_ready_M            : data memory done (0 = access pending)
//   Stall_F/D/E/M           : hold PC / F-D / D-E / E-M
//   Flush_D/E/W             : clear F-D / D-E / M-W
//   stall_cnt, flush_cnt    : registered, saturating perf counters
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic              MemRead_E,
    input  logic              PCSrc_E,
    input  logic              imem_valid_F,
    input  logic              dmem_ready_M,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Flush_D,
    output logic              Stall_E,
    output logic              Flush_E,
    output logic              Stall_M,
    output logic              Flush_W,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    logic lu;
    logic in_drop;

    assign lu = MemRead_E && (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    assign in_drop = (state_q == DROP);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. MEM_WAIT with ready behaves exactly like RUN.
    always_comb begin
        state_d = RUN;
        if (!dmem_ready_M) begin
            state_d = MEM_WAIT;
        end else if (PCSrc_E) begin
            // Redirect with a fetch still in flight, or a fresh redirect while
            // already discarding, leaves a stale word to drop.
            state_d = (!imem_valid_F || in_drop) ? DROP : RUN;
        end else if (in_drop && !imem_valid_F) begin
            state_d = DROP;
        end
    end

    // Output logic: zero while in reset, otherwise priority mux.
    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Flush_D = 1'b0;
        Stall_E = 1'b0;
        Flush_E = 1'b0;
        Stall_M = 1'b0;
        Flush_W = 1'b0;
        if (rst) begin
            if (!dmem_ready_M) begin
                // Freeze everything upstream of M; bubble into W.
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
                Flush_W = 1'b1;
            end else if (PCSrc_E) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else begin
                if (lu) begin
                    Stall_F = 1'b1;
                    Stall_D = 1'b1;
                    Flush_E = 1'b1;
                end else if (!imem_valid_F) begin
                    Stall_F = 1'b1;
                    Flush_D = 1'b1;
                end
                // In DROP the word arriving on the fetch port is stale: always
                // discard it, and let PC advance once it has come back.
                if (in_drop) begin
                    Flush_D = 1'b1;
                    Stall_F = !imem_valid_F;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (Stall_F),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (Flush_D | Flush_E),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;   // narrow counters so saturation is reachable

    // Control vector order: {Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Flush_W}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LU    = 7'b1100100;
    localparam logic [6:0] C_RED   = 7'b0010100;
    localparam logic [6:0] C_FRZ   = 7'b1101011;
    localparam logic [6:0] C_FETCH = 7'b1010000;
    localparam logic [6:0] C_DROPV = 7'b0010000;

    typedef struct packed {
        logic [6:0]    ctrl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1_D, Rs2_D, Rd_E;
    logic          MemRead_E, PCSrc_E, imem_valid_F, dmem_ready_M;
    logic          Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Flush_W;
    logic [CW-1:0] stall_cnt, flush_cnt;

    exp_t obs;
    exp_t e;
    exp_t q[$];
    logic [CW-1:0] m_sc, m_fc;
    int checks = 0;
    int errors = 0;

    assign obs = {Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Flush_W,
                  stall_cnt, flush_cnt};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW (AW),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Rs1_D        (Rs1_D),
        .Rs2_D        (Rs2_D),
        .Rd_E         (Rd_E),
        .MemRead_E    (MemRead_E),
        .PCSrc_E      (PCSrc_E),
        .imem_valid_F (imem_valid_F),
        .dmem_ready_M (dmem_ready_M),
        .Stall_F      (Stall_F),
        .Stall_D      (Stall_D),
        .Flush_D      (Flush_D),
        .Stall_E      (Stall_E),
        .Flush_E      (Flush_E),
        .Stall_M      (Stall_M),
        .Flush_W      (Flush_W),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Apply inputs and queue the expected result; the model counters advance by
    // the expected flags at the coming edge.
    task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic mr, input logic pc,
                         input logic iv, input logic dr, input logic [6:0] ctrl);
        Rs1_D = rs1; Rs2_D = rs2; Rd_E = rd; MemRead_E = mr;
        PCSrc_E = pc; imem_valid_F = iv; dmem_ready_M = dr;
        q.push_back('{ctrl: ctrl, sc: m_sc, fc: m_fc});
        if (ctrl[6] && m_sc != '1) m_sc = m_sc + 1'b1;
        if ((ctrl[4] || ctrl[2]) && m_fc != '1) m_fc = m_fc + 1'b1;
    endtask

    task automatic idle(input logic [6:0] ctrl);
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, ctrl);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Rs1_D = AW'($urandom); Rs2_D = AW'($urandom); Rd_E = AW'($urandom);
            MemRead_E = 1'($urandom); PCSrc_E = 1'($urandom);
            imem_valid_F = 1'($urandom); dmem_ready_M = 1'($urandom);
            q.push_back('0);
            @(negedge clk);
            e = q.pop_front(); checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
        m_sc = '0; m_fc = '0;
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        exp_t tbl_dummy;
        tbl_dummy = '0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, C_LU);
                1: idle(C_NONE);                                            // stall_cnt now 1
                2: drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, C_NONE); // Rd_E = x0
                3: drive(5'd4, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, C_LU);   // match on rs2
                default: drive(5'd4, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE); // not a load
            endcase
            @(negedge clk);
            e = q.pop_front(); checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL load_use[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
        if (tbl_dummy != '0) errors++;
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, C_RED);
                1: idle(C_NONE);     // back in RUN, flush_cnt +1
                default: drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_FETCH);
            endcase
            @(negedge clk);
            e = q.pop_front(); checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL redirect[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_drop();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, C_RED);
                1, 2: drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_FETCH);
                3: idle(C_DROPV);    // stale word returns: discarded, PC advances
                default: idle(C_NONE);
            endcase
            @(negedge clk);
            e = q.pop_front(); checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL redirect_drop[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, C_FRZ);
            else if (i == 4) drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, C_RED);
            else if (i == 5) idle(C_NONE);
            else drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, C_LU);
            @(negedge clk);
            e = q.pop_front(); checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_FETCH);
            @(negedge clk);
            e = q.pop_front(); checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL saturation[%0d]: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
        idle(C_NONE);
        @(negedge clk);
        e = q.pop_front(); checks++;
        if (stall_cnt !== {CW{1'b1}} || obs !== e) begin
            errors++;
            $display("FAIL saturation_hold: got %h expected %h (stall_cnt %0d)", obs, e, stall_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, C_RED);
        @(negedge clk);
        e = q.pop_front(); checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_reset_enter: got %h expected %h", obs, e);
        end
        @(posedge clk); #1;
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_FETCH);   // in DROP
        @(negedge clk);
        e = q.pop_front(); checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_reset_drop: got %h expected %h", obs, e);
        end
        #2 rst = 1'b0;
        m_sc = '0; m_fc = '0;
        q.push_back('0);
        #1;
        e = q.pop_front(); checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_reset_now: got %h expected %h", obs, e);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        idle(C_NONE);        // in DROP this would flush D
        @(negedge clk);
        e = q.pop_front(); checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_reset_run: got %h expected %h", obs, e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_sc = '0; m_fc = '0;
        rst = 1'b0;
        Rs1_D = '0; Rs2_D = '0; Rd_E = '0; MemRead_E = 1'b0; PCSrc_E = 1'b0;
        imem_valid_F = 1'b1; dmem_ready_M = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_redirect_drop();
        test_mem_wait();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
